// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction memory and IF/ID pipeline register.
//   Parameters: IMEM_DEPTH (words, 8-bit PC index), RESET_PC (PC after reset).
//   Inputs : clk, rst_n (async active-low), stall, flush, br_taken, br_target[7:0],
//            imem_we, imem_addr[7:0], imem_wdata[31:0] (program-load port).
//   Outputs: instr[31:0], pc_out[7:0], valid, opcode/rd/rs/rt[3:0], imm[15:0],
//            halted (only when FETCH_HALT_EN is defined).
//   Macro FETCH_HALT_EN: opcode 4'hF freezes fetch until br_taken or reset.
module fetch_stage #(
    parameter int         IMEM_DEPTH = 256,
    parameter logic [7:0] RESET_PC   = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [7:0]  br_target,
    input  logic        imem_we,
    input  logic [7:0]  imem_addr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] instr,
    output logic [7:0]  pc_out,
    output logic        valid,
    output logic [3:0]  opcode,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [3:0]  rt,
    output logic [15:0] imm
`ifdef FETCH_HALT_EN
    ,
    output logic        halted
`endif
);
    logic [31:0] imem [IMEM_DEPTH];
    logic [7:0]  pc;
    logic [31:0] fetch_word;
    logic        idle;

    // Memory is never reset; the nonblocking write makes a same-edge fetch see the old word.
    always_ff @(posedge clk)
        if (imem_we) imem[imem_addr] <= imem_wdata;

    assign fetch_word = imem[pc];

`ifdef FETCH_HALT_EN
    assign idle = halted;
    // Halt latches only when an opcode-F word really enters IF/ID.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) halted <= 1'b0;
        else if (br_taken) halted <= 1'b0;
        else if (!flush && !stall && !halted && fetch_word[31:28] == 4'hF) halted <= 1'b1;
`else
    assign idle = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc     <= RESET_PC;
            instr  <= '0;
            pc_out <= '0;
            valid  <= 1'b0;
        end else begin
            pc <= br_taken ? br_target : (stall || idle) ? pc : pc + 8'd1;
            // A redirect kills the word fetched down the wrong path; pc_out keeps its value.
            if (flush || br_taken || idle) begin
                instr <= '0;
                valid <= 1'b0;
            end else if (!stall) begin
                instr  <= fetch_word;
                pc_out <= pc;
                valid  <= 1'b1;
            end
        end

    assign opcode = instr[31:28];
    assign rd     = instr[27:24];
    assign rs     = instr[23:20];
    assign rt     = instr[19:16];
    assign imm    = instr[15:0];
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table, hand-written and random checks of fetch_stage against a reference model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, br_taken = 1'b0, imem_we = 1'b0;
    logic [7:0]  br_target = '0, imem_addr = '0;
    logic [31:0] imem_wdata = '0;
    logic [31:0] instr;
    logic [7:0]  pc_out;
    logic        valid;
    logic [3:0]  opcode, rd, rs, rt;
    logic [15:0] imm;
`ifdef FETCH_HALT_EN
    logic        halted;
`endif

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .br_taken(br_taken), .br_target(br_target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .instr(instr), .pc_out(pc_out), .valid(valid),
        .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm(imm)
`ifdef FETCH_HALT_EN
        , .halted(halted)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural view only (memory image, PC, IF/ID contents).
    logic [31:0] shadow [256];
    logic [7:0]  m_pc, m_pc_out;
    logic [31:0] m_instr;
    logic        m_valid;

    typedef struct {
        logic       s, f, b;
        logic [7:0] t;
        logic [7:0] pc;
        logic       v;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_pc_out = 8'h00; m_instr = '0; m_valid = 1'b0;
    endtask

    task automatic tick(input logic s, input logic f, input logic b, input logic [7:0] t,
                        input logic we, input logic [7:0] wa, input logic [31:0] wd);
        logic [31:0] fetched;
        stall = s; flush = f; br_taken = b; br_target = t;
        imem_we = we; imem_addr = wa; imem_wdata = wd;
        @(posedge clk);
        fetched = shadow[m_pc];
        if (we) shadow[wa] = wd;
        if (b || f) begin
            m_instr = '0; m_valid = 1'b0;
        end else if (!s) begin
            m_instr = fetched; m_pc_out = m_pc; m_valid = 1'b1;
        end
        m_pc = b ? t : s ? m_pc : m_pc + 8'd1;
        #1;
        stall = 1'b0; flush = 1'b0; br_taken = 1'b0; imem_we = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_instr"}, instr, m_instr);
        chk({tag, "_pc_out"}, {24'h0, pc_out}, {24'h0, m_pc_out});
        chk({tag, "_valid"}, {31'h0, valid}, {31'h0, m_valid});
        chk({tag, "_fields"}, {opcode, rd, rs, rt, imm}, m_instr);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] d;
        d = $urandom;
        if (d[31:28] == 4'hF) d[31:28] = 4'h7;
        return d;
    endfunction

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h40, 8'h04, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h40, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h42, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h42, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h43, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 8'hFE, 8'h43, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hFE, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};

        // Asynchronous reset: no clock edge between assertion and check.
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc_out", {24'h0, pc_out}, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);

        // Load the whole program while reset is held.
        for (int i = 0; i < 256; i++) begin
            imem_we = 1'b1; imem_addr = 8'(i);
            imem_wdata = (i == 0) ? 32'h1234_0005 : (i == 1) ? 32'h2567_0000 : rnd_word();
            shadow[i] = imem_wdata;
            @(posedge clk); #1;
        end
        imem_we = 1'b0;
        chk("rst_hold_valid", {31'h0, valid}, 32'h0);
        rst_n = 1'b1;
        #2;
        chk("rel_pc_out", {24'h0, pc_out}, 32'h0);

        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].s, tbl[i].f, tbl[i].b, tbl[i].t, 1'b0, 8'h00, 32'h0);
            chk($sformatf("tbl%0d_pc_out", i), {24'h0, pc_out}, {24'h0, tbl[i].pc});
            chk($sformatf("tbl%0d_valid", i), {31'h0, valid}, {31'h0, tbl[i].v});
            chk($sformatf("tbl%0d_instr", i), instr, tbl[i].v ? shadow[tbl[i].pc] : 32'h0);
            chk($sformatf("tbl%0d_fields", i), {opcode, rd, rs, rt, imm}, tbl[i].v ? shadow[tbl[i].pc] : 32'h0);
            if (i == 0) begin
                chk("first_instr", instr, 32'h1234_0005);
                chk("first_rd", {28'h0, rd}, 32'd2);
                chk("first_rs", {28'h0, rs}, 32'd3);
                chk("first_rt", {28'h0, rt}, 32'd4);
                chk("first_imm", {16'h0, imm}, 32'd5);
            end
        end

        // Read-before-write: PC is 1 here; overwrite word 1 on the edge that fetches it.
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 32'hDEAD_BEEF);
        chk("rbw_old", instr, 32'h2567_0000);
        chk_model("rbw_old");
        tick(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 32'h0);
        chk_model("rbw_br");
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
        chk("rbw_new", instr, 32'hDEAD_BEEF);
        chk_model("rbw_new");

        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 8'($urandom), $urandom_range(0, 4) == 0, 8'($urandom), rnd_word());
            chk_model($sformatf("rnd%0d", i));
        end

        // Reset in the middle of a stalled branch: nothing pending survives.
        stall = 1'b1; br_taken = 1'b1; br_target = 8'h80;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        chk_model("midrst");
        stall = 1'b0; br_taken = 1'b0;
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
        chk_model("postrst");
        chk("postrst_pc0", {24'h0, pc_out}, 32'h0);

        // Opcode-F word at address 2.
        tick(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h02, 32'hF000_0000);
        chk_model("h_br");
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
        chk_model("h_pc0");
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
        chk_model("h_pc1");
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
        chk_model("h_pc2");
        chk("h_word", instr, 32'hF000_0000);
`ifdef FETCH_HALT_EN
        chk("h_halted_set", {31'h0, halted}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
            chk("h_frozen_valid", {31'h0, valid}, 32'h0);
            chk("h_frozen_pc_out", {24'h0, pc_out}, 32'h2);
            chk("h_frozen_halted", {31'h0, halted}, 32'h1);
        end
        tick(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 32'h0);
        chk("h_clear_halted", {31'h0, halted}, 32'h0);
        chk("h_clear_valid", {31'h0, valid}, 32'h0);
`else
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
            chk_model("noh_run");
        end
        chk("noh_pc_out", {24'h0, pc_out}, 32'h5);
        tick(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 32'h0);
        chk_model("noh_br");
`endif
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
        chk_model("h_resume");
        chk("h_resume_pc0", {24'h0, pc_out}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
